// File: rtl/mac_mul_seq_if.sv
// Operand, row-multiplier and product bundle for the sequential MAC multiplier.
// The slave modport is the sequencer's view; the master modport is its environment.
interface mac_mul_seq_if;
  localparam int unsigned CONF_W = 3;
  localparam int unsigned MIN_W  = 8;
  localparam int unsigned INT_W  = 5 * MIN_W;
  localparam int unsigned ACC_W  = 8 * MIN_W;
  localparam int unsigned OPD_W  = 4 * MIN_W;

  logic              in_valid;
  logic              in_ready;
  logic [OPD_W-1:0]  in_a;
  logic [OPD_W-1:0]  in_b;
  logic [CONF_W-1:0] in_cfg;

  logic [MIN_W-1:0]  row_a0;
  logic [MIN_W-1:0]  row_a1;
  logic [MIN_W-1:0]  row_a2;
  logic [MIN_W-1:0]  row_a3;
  logic [MIN_W-1:0]  row_b0;
  logic [CONF_W-1:0] row_cfg;
  logic [INT_W-1:0]  row_c;

  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_p;
  logic [CONF_W-1:0] out_cfg;

  modport slave (
    input  in_valid, in_a, in_b, in_cfg, row_c, out_ready,
    output in_ready, row_a0, row_a1, row_a2, row_a3, row_b0, row_cfg,
           out_valid, out_p, out_cfg
  );

  modport master (
    output in_valid, in_a, in_b, in_cfg, row_c, out_ready,
    input  in_ready, row_a0, row_a1, row_a2, row_a3, row_b0, row_cfg,
           out_valid, out_p, out_cfg
  );
endinterface

// File: rtl/mac_mul_seq.sv
// Multi-cycle initiator for the single-row MAC multiplier: feeds one B slice per
// cycle, shift-accumulates the returned row products and hands back the product.
module mac_mul_seq (
  input  logic          clk,
  input  logic          rst_n,
  mac_mul_seq_if.slave  bus
);
  localparam int unsigned CONF_W = 3;
  localparam int unsigned MIN_W  = 8;
  localparam int unsigned ACC_W  = 8 * MIN_W;
  localparam int unsigned OPD_W  = 4 * MIN_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [OPD_W-1:0]  r_b;
  logic [CONF_W-1:0] r_cfg;
  logic [1:0]        r_last;
  logic [1:0]        r_idx;
  logic [ACC_W-1:0]  r_acc;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [OPD_W-1:0]  r_row_a;
  logic [MIN_W-1:0]  r_row_b0;
  logic [CONF_W-1:0] r_row_cfg;

  logic              w_accept;
  logic              w_out_fire;
  logic              w_run_last;
  logic [CONF_W-1:0] w_cfg_norm;
  logic [1:0]        w_last;
  logic [OPD_W-1:0]  w_mask;
  logic [1:0]        w_idx_nxt;
  logic [MIN_W-1:0]  w_b_slice;
  logic [ACC_W-1:0]  w_row_term;

  assign w_accept   = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;
  assign w_run_last = (r_idx == r_last);
  assign w_idx_nxt  = r_idx + 2'd1;
  assign w_b_slice  = r_b[32'(w_idx_nxt) * MIN_W +: MIN_W];
  assign w_row_term = ACC_W'(bus.row_c) << (32'(r_idx) * MIN_W);

  // Unknown config codes fall back to single width; mask keeps only active slices.
  always_comb begin
    w_cfg_norm = CONF_W'(0);
    w_last     = 2'd0;
    w_mask     = OPD_W'(8'hFF);
    case (bus.in_cfg)
      3'b001: begin
        w_cfg_norm = 3'b001;
        w_last     = 2'd1;
        w_mask     = OPD_W'(16'hFFFF);
      end
      3'b010: begin
        w_cfg_norm = 3'b010;
        w_last     = 2'd3;
        w_mask     = '1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)   w_state_nxt = S_RUN;
      S_RUN:   if (w_run_last) w_state_nxt = S_DONE;
      S_DONE:  if (w_out_fire) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Row outputs are loaded one edge ahead so each RUN cycle presents slice[idx].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b         <= '0;
      r_cfg       <= '0;
      r_last      <= '0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_row_a     <= '0;
      r_row_b0    <= '0;
      r_row_cfg   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_b        <= bus.in_b & w_mask;
            r_cfg      <= w_cfg_norm;
            r_last     <= w_last;
            r_idx      <= '0;
            r_acc      <= '0;
            r_in_ready <= 1'b0;
            r_row_a    <= bus.in_a & w_mask;
            r_row_b0   <= bus.in_b[MIN_W-1:0];
            r_row_cfg  <= w_cfg_norm;
          end
        end
        S_RUN: begin
          r_acc <= r_acc + w_row_term;
          r_idx <= w_idx_nxt;
          if (w_run_last) begin
            r_row_a     <= '0;
            r_row_b0    <= '0;
            r_row_cfg   <= '0;
            r_out_valid <= 1'b1;
          end else begin
            r_row_b0 <= w_b_slice;
          end
        end
        S_DONE: begin
          if (w_out_fire) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_p     = r_acc;
  assign bus.out_cfg   = r_cfg;
  assign bus.row_a0    = r_row_a[MIN_W-1:0];
  assign bus.row_a1    = r_row_a[2*MIN_W-1:MIN_W];
  assign bus.row_a2    = r_row_a[3*MIN_W-1:2*MIN_W];
  assign bus.row_a3    = r_row_a[4*MIN_W-1:3*MIN_W];
  assign bus.row_b0    = r_row_b0;
  assign bus.row_cfg   = r_row_cfg;
endmodule

// File: tb/tb_mac_mul_seq.sv
// Self-checking bench for mac_mul_seq: directed vector table, backpressure and
// mid-operation reset sequences, and random operations against an a*b model.
module tb_mac_mul_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mac_mul_seq_if bus ();

  mac_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Row multiplier: combinational product of the active A word and the B slice.
  assign bus.row_c = 40'({bus.row_a3, bus.row_a2, bus.row_a1, bus.row_a0}) * 40'(bus.row_b0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  cfg;
    logic [63:0] p;
    logic [2:0]  ocfg;
    int          n;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slices_of(input logic [2:0] cfg);
    if (cfg == 3'b001) return 2;
    if (cfg == 3'b010) return 4;
    return 1;
  endfunction

  function automatic logic [31:0] keep_mask(input int n);
    logic [31:0] m;
    if (n >= 4) m = 32'hFFFF_FFFF;
    else        m = (32'd1 << (8 * n)) - 32'd1;
    return m;
  endfunction

  // Drive one operation, check rows each RUN cycle, latency, product and release.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] cfg, input logic [63:0] exp_p,
                        input logic [2:0] exp_cfg, input int n, input int hold);
    int          lat;
    int          k;
    logic [31:0] am;
    logic [7:0]  bexp;
    am = keep_mask(n);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cfg    = cfg;
    bus.out_ready = (hold == 0);
    k = 0;
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({nm, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_cfg   = 3'($urandom);
    lat = 1;
    k   = 0;
    while (!bus.out_valid && lat <= 8) begin
      bexp = (k < n) ? 8'(b >> (8 * k)) : 8'h00;
      check({nm, " row_b0"}, 64'(bus.row_b0), 64'(bexp));
      check({nm, " row_a"}, 64'({bus.row_a3, bus.row_a2, bus.row_a1, bus.row_a0}), 64'(a & am));
      check({nm, " row_cfg"}, 64'(bus.row_cfg), 64'(exp_cfg));
      k++;
      lat++;
      @(negedge clk);
    end
    check({nm, " latency"}, 64'(lat), 64'(n + 1));
    check({nm, " out_p"}, bus.out_p, exp_p);
    check({nm, " out_cfg"}, 64'(bus.out_cfg), 64'(exp_cfg));
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({nm, " held valid"}, 64'(bus.out_valid), 64'd1);
        check({nm, " held out_p"}, bus.out_p, exp_p);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({nm, " valid drop"}, 64'(bus.out_valid), 64'd0);
    check({nm, " ready back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    vecs[0] = '{"single_ff",   32'h0000_00FF, 32'h0000_00FF, 3'b000, 64'h0000_0000_0000_FE01, 3'b000, 1};
    vecs[1] = '{"dual_ffff",   32'h0000_FFFF, 32'h0000_FFFF, 3'b001, 64'h0000_0000_FFFE_0001, 3'b001, 2};
    vecs[2] = '{"quad_max",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b010, 64'hFFFF_FFFE_0000_0001, 3'b010, 4};
    vecs[3] = '{"single_hi",   32'hAB00_0003, 32'hCD00_0005, 3'b000, 64'h0000_0000_0000_000F, 3'b000, 1};
    vecs[4] = '{"cfg011",      32'h1234_5610, 32'h9876_5420, 3'b011, 64'h0000_0000_0000_0200, 3'b000, 1};
    vecs[5] = '{"cfg111",      32'hFF00_0007, 32'h0000_0009, 3'b111, 64'h0000_0000_0000_003F, 3'b000, 1};
    vecs[6] = '{"dual_mask",   32'h0001_1234, 32'h0002_0010, 3'b001, 64'h0000_0000_0001_2340, 3'b001, 2};
    vecs[7] = '{"quad_mid",    32'h0001_0000, 32'h0001_0000, 3'b010, 64'h0000_0001_0000_0000, 3'b010, 4};
    vecs[8] = '{"quad_top",    32'h8000_0000, 32'h0000_0002, 3'b010, 64'h0000_0001_0000_0000, 3'b010, 4};
    vecs[9] = '{"dual_zero",   32'h0000_0000, 32'h0000_FFFF, 3'b001, 64'h0000_0000_0000_0000, 3'b001, 2};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cfg    = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_p", bus.out_p, 64'd0);
    check("rst out_cfg", 64'(bus.out_cfg), 64'd0);
    check("rst row", 64'({bus.row_a3, bus.row_a2, bus.row_a1, bus.row_a0, bus.row_b0, bus.row_cfg}), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].nm, vecs[i].a, vecs[i].b, vecs[i].cfg, vecs[i].p, vecs[i].ocfg, vecs[i].n, 0);

    // Backpressure: product held for 10 cycles while a second request is ignored.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_a      = 32'd5;
    bus.in_b      = 32'd7;
    bus.in_cfg    = 3'b000;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_a = 32'd9;
    bus.in_b = 32'd9;
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
    check("bp valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp hold valid", 64'(bus.out_valid), 64'd1);
      check("bp hold p", bus.out_p, 64'h23);
      check("bp in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp release valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp no second accept", 64'(bus.in_ready), 64'd1);
      check("bp no second valid", 64'(bus.out_valid), 64'd0);
    end

    // Reset pulse during a quad operation while idx = 2 is on the row bus.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'hFFFF_FFFF;
    bus.in_b     = 32'h4433_2211;
    bus.in_cfg   = 3'b010;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rr row_b0 idx2", 64'(bus.row_b0), 64'h33);
    rst_n = 1'b0;
    #1;
    check("rr in_ready", 64'(bus.in_ready), 64'd1);
    check("rr out_valid", 64'(bus.out_valid), 64'd0);
    check("rr row_b0", 64'(bus.row_b0), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rr no product", 64'(bus.out_valid), 64'd0);
    end
    run_op("rr_single", 32'd3, 32'd4, 3'b000, 64'h000C, 3'b000, 1, 0);

    // Random operations against the plain-arithmetic product model.
    for (int i = 0; i < 1300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rc;
      int          n;
      logic [31:0] m;
      ra = $urandom;
      rb = $urandom;
      rc = (i < 1000) ? 3'b010 : 3'($urandom);
      n  = slices_of(rc);
      m  = keep_mask(n);
      run_op("rand", ra, rb, rc, 64'(ra & m) * 64'(rb & m),
             (rc <= 3'b010) ? rc : 3'b000, n, int'($urandom_range(0, 2)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
